// File: rtl/oram_store_buffer.sv
// oram_store_buffer: accepts a store command, captures one MXU result tile,
// then streams the requested rows into the ORAM one row per cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a store command (ctrl_st_rdy=1)
// WAIT_DATA | command latched, waiting for the MXU tile (buf_mxu_rdy=1)
// WRITE     | driving one ORAM row write per cycle
// DONE      | single-cycle st_done pulse, then back to IDLE
module oram_store_buffer #(
  parameter int ADDR_W = 8,
  parameter int ROWS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_st_vld,
  output logic                  ctrl_st_rdy,
  input  logic [ADDR_W-1:0]     ctrl_st_start_addr,
  input  logic [3:0]            ctrl_st_row_len,
  input  logic                  ctrl_st_row_dir,
  input  logic                  mxu_data_vld,
  input  logic [128*ROWS-1:0]   mxu_data,
  output logic                  buf_mxu_rdy,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [127:0]          ram_din,
  output logic                  st_done
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, WRITE, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   start_addr;
  logic [3:0]          row_len;
  logic                row_dir;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nxt;
  logic [127:0]        tile [ROWS];

  assign cnt_nxt = cnt + 4'd1;

  // Tile buffer: loaded only on the capture edge; never reset since its
  // contents are meaningless until a capture happens.
  always_ff @(posedge clk) begin
    if (state == WAIT_DATA && mxu_data_vld) begin
      for (int i = 0; i < ROWS; i++) begin
        tile[i] <= mxu_data[128*i +: 128];
      end
    end
  end

  // Sequencer with registered outputs. Row 0 is driven straight from the
  // incoming tile on the capture edge so the first write lands one cycle
  // later; subsequent rows come from the buffer, addressed one row ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      start_addr  <= '0;
      row_len     <= '0;
      row_dir     <= 1'b0;
      ctrl_st_rdy <= 1'b1;
      buf_mxu_rdy <= 1'b0;
      ram_cen     <= 1'b0;
      ram_wen     <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      st_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_st_vld && ctrl_st_rdy) begin
            start_addr  <= ctrl_st_start_addr;
            row_len     <= ctrl_st_row_len;
            row_dir     <= ctrl_st_row_dir;
            cnt         <= '0;
            ctrl_st_rdy <= 1'b0;
            buf_mxu_rdy <= 1'b1;
            state       <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (mxu_data_vld) begin
            buf_mxu_rdy <= 1'b0;
            ram_cen     <= 1'b1;
            ram_wen     <= 1'b1;
            ram_addr    <= start_addr;
            ram_din     <= mxu_data[127:0];
            cnt         <= '0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          cnt <= cnt_nxt;
          if (cnt == row_len) begin
            ram_cen  <= 1'b0;
            ram_wen  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            st_done  <= 1'b1;
            state    <= DONE;
          end else begin
            // Address arithmetic wraps naturally at the ADDR_W boundary.
            ram_addr <= row_dir ? start_addr + ADDR_W'(cnt_nxt)
                                : start_addr - ADDR_W'(cnt_nxt);
            ram_din  <= tile[cnt_nxt];
          end
        end
        DONE: begin
          st_done     <= 1'b0;
          ctrl_st_rdy <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oram_store_buffer.sv
// Directed + randomized bench for oram_store_buffer. Expected writes are
// derived from the command (address = start +/- k mod 256) and the tile
// the bench itself generated.
module tb_oram_store_buffer;

  localparam int ADDR_W = 8;
  localparam int ROWS   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ctrl_st_vld;
  logic                 ctrl_st_rdy;
  logic [ADDR_W-1:0]    ctrl_st_start_addr;
  logic [3:0]           ctrl_st_row_len;
  logic                 ctrl_st_row_dir;
  logic                 mxu_data_vld;
  logic [128*ROWS-1:0]  mxu_data;
  logic                 buf_mxu_rdy;
  logic                 ram_cen;
  logic                 ram_wen;
  logic [ADDR_W-1:0]    ram_addr;
  logic [127:0]         ram_din;
  logic                 st_done;

  int checks = 0;
  int fails  = 0;

  logic [127:0] tile_m [ROWS];

  oram_store_buffer #(.ADDR_W(ADDR_W), .ROWS(ROWS)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ctrl_st_vld        (ctrl_st_vld),
    .ctrl_st_rdy        (ctrl_st_rdy),
    .ctrl_st_start_addr (ctrl_st_start_addr),
    .ctrl_st_row_len    (ctrl_st_row_len),
    .ctrl_st_row_dir    (ctrl_st_row_dir),
    .mxu_data_vld       (mxu_data_vld),
    .mxu_data           (mxu_data),
    .buf_mxu_rdy        (buf_mxu_rdy),
    .ram_cen            (ram_cen),
    .ram_wen            (ram_wen),
    .ram_addr           (ram_addr),
    .ram_din            (ram_din),
    .st_done            (st_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int start, input int k, input bit dir);
    int a;
    a = dir ? start + k : start - k;
    return 8'(((a % 256) + 256) % 256);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_tile();
    for (int i = 0; i < ROWS; i++) tile_m[i] = rand128();
  endtask

  task automatic rand_bus();
    for (int i = 0; i < ROWS; i++) mxu_data[128*i +: 128] = rand128();
  endtask

  // Called at a negedge while in IDLE; returns at the negedge of WAIT_DATA.
  task automatic do_cmd(input logic [7:0] start, input logic [3:0] len, input logic dir);
    ctrl_st_vld        = 1'b1;
    ctrl_st_start_addr = start;
    ctrl_st_row_len    = len;
    ctrl_st_row_dir    = dir;
    @(negedge clk);
    ctrl_st_vld        = 1'b0;
    ctrl_st_start_addr = 8'($urandom);
    ctrl_st_row_len    = 4'($urandom);
    ctrl_st_row_dir    = 1'($urandom);
    chk("wait_buf_rdy", buf_mxu_rdy, 1'b1);
    chk("wait_ctrl_rdy", ctrl_st_rdy, 1'b0);
  endtask

  // Presents tile_m for one cycle; returns at the negedge of the first write.
  task automatic send_tile();
    for (int i = 0; i < ROWS; i++) mxu_data[128*i +: 128] = tile_m[i];
    mxu_data_vld = 1'b1;
    @(negedge clk);
    mxu_data_vld = 1'b0;
    rand_bus();
  endtask

  // Checks len+1 back-to-back writes, the done pulse, then the IDLE cycle.
  task automatic run_writes(input int start, input int len, input bit dir);
    for (int k = 0; k <= len; k++) begin
      chk("wr_cen", ram_cen, 1'b1);
      chk("wr_wen", ram_wen, 1'b1);
      chk("wr_addr", ram_addr, exp_addr(start, k, dir));
      chk("wr_din", ram_din, tile_m[k]);
      chk("wr_busy_rdy", ctrl_st_rdy, 1'b0);
      chk("wr_no_done", st_done, 1'b0);
      @(negedge clk);
    end
    chk("done_pulse", st_done, 1'b1);
    chk("done_cen", ram_cen, 1'b0);
    chk("done_addr", ram_addr, 8'h00);
    @(negedge clk);
    chk("done_clear", st_done, 1'b0);
    chk("idle_rdy", ctrl_st_rdy, 1'b1);
    chk("idle_cen", ram_cen, 1'b0);
  endtask

  initial begin
    rst_n              = 1'b0;
    ctrl_st_vld        = 1'b0;
    ctrl_st_start_addr = '0;
    ctrl_st_row_len    = '0;
    ctrl_st_row_dir    = 1'b0;
    mxu_data_vld       = 1'b0;
    mxu_data           = '0;
    #12;
    chk("rst_ctrl_rdy", ctrl_st_rdy, 1'b1);
    chk("rst_buf_rdy", buf_mxu_rdy, 1'b0);
    chk("rst_cen", ram_cen, 1'b0);
    chk("rst_wen", ram_wen, 1'b0);
    chk("rst_addr", ram_addr, 8'h00);
    chk("rst_din", ram_din, 128'h0);
    chk("rst_done", st_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Incrementing run with row i = {16{i}}.
    for (int i = 0; i < ROWS; i++) tile_m[i] = {16{8'(i)}};
    do_cmd(8'h10, 4'd3, 1'b1);
    send_tile();
    run_writes(8'h10, 3, 1'b1);

    // Wrap upward past 0xFF, then downward past 0x00.
    rand_tile();
    do_cmd(8'hFE, 4'd3, 1'b1);
    send_tile();
    run_writes(8'hFE, 3, 1'b1);
    rand_tile();
    do_cmd(8'h01, 4'd2, 1'b0);
    send_tile();
    run_writes(8'h01, 2, 1'b0);

    // Stray tile pulse in IDLE must be ignored.
    rand_bus();
    mxu_data_vld = 1'b1;
    @(negedge clk);
    mxu_data_vld = 1'b0;
    chk("stray_buf_rdy", buf_mxu_rdy, 1'b0);
    chk("stray_ctrl_rdy", ctrl_st_rdy, 1'b1);
    chk("stray_cen", ram_cen, 1'b0);
    rand_tile();
    tile_m[0] = {16{8'hAA}};
    do_cmd(8'h33, 4'd2, 1'b1);
    send_tile();
    run_writes(8'h33, 2, 1'b1);

    // Full 16-row tile with a new command held valid throughout.
    rand_tile();
    do_cmd(8'h80, 4'd15, 1'b1);
    ctrl_st_vld        = 1'b1;
    ctrl_st_start_addr = 8'h40;
    ctrl_st_row_len    = 4'd0;
    ctrl_st_row_dir    = 1'b1;
    send_tile();
    run_writes(8'h80, 15, 1'b1);
    @(negedge clk);
    ctrl_st_vld = 1'b0;
    chk("held_cmd_accepted", buf_mxu_rdy, 1'b1);
    rand_tile();
    send_tile();
    run_writes(8'h40, 0, 1'b1);

    // Reset during the third write of an 8-row command.
    rand_tile();
    do_cmd(8'h20, 4'd7, 1'b1);
    send_tile();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_addr", ram_addr, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cen", ram_cen, 1'b0);
    chk("async_rst_rdy", ctrl_st_rdy, 1'b1);
    chk("async_rst_addr", ram_addr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_cen", ram_cen, 1'b0);
      chk("post_rst_done", st_done, 1'b0);
      chk("post_rst_rdy", ctrl_st_rdy, 1'b1);
    end

    // Single-row command.
    rand_tile();
    do_cmd(8'h00, 4'd0, 1'b0);
    send_tile();
    run_writes(8'h00, 0, 1'b0);

    // Random commands with a random tile delay.
    for (int r = 0; r < 6; r++) begin
      int st, ln, dw;
      bit dr;
      st = $urandom_range(0, 255);
      ln = $urandom_range(0, 15);
      dr = 1'($urandom_range(0, 1));
      dw = $urandom_range(0, 3);
      rand_tile();
      do_cmd(8'(st), 4'(ln), dr);
      for (int w = 0; w < dw; w++) begin
        @(negedge clk);
        chk("rnd_wait_buf_rdy", buf_mxu_rdy, 1'b1);
        chk("rnd_wait_cen", ram_cen, 1'b0);
      end
      send_tile();
      run_writes(st, ln, dr);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/oram_store_buffer.md
ORAM_STORE_BUFFER -- requirements
Module: oram_store_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, ORAM word-address width.
REQ-002 SHALL have parameter ROWS, default 16, MXU result rows per tile (fixed 16; the row-count field is 4 bits).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ctrl_st_vld  input  1  store-command valid from LSU control.
REQ-006 SHALL have port ctrl_st_rdy  output  1  block can accept a command.
REQ-007 SHALL have port ctrl_st_start_addr  input  ADDR_W  ORAM address of first row written.
REQ-008 SHALL have port ctrl_st_row_len  input  4  rows to write minus one (0..15).
REQ-009 SHALL have port ctrl_st_row_dir  input  1  1 = address increments per row, 0 = decrements.
REQ-010 SHALL have port mxu_data_vld  input  1  MXU result tile valid (single-cycle pulse).
REQ-011 SHALL have port mxu_data  input  128*ROWS  result tile; row i at bits [128i+127:128i], int8 lanes.
REQ-012 SHALL have port buf_mxu_rdy  output  1  block is waiting for a tile.
REQ-013 SHALL have port ram_cen  output  1  ORAM access enable, active-high.
REQ-014 SHALL have port ram_wen  output  1  ORAM write enable, active-high.
REQ-015 SHALL have port ram_addr  output  ADDR_W  ORAM word address.
REQ-016 SHALL have port ram_din  output  128  ORAM write data.
REQ-017 SHALL have port st_done  output  1  one-cycle pulse after the last row of a command has been written.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_DATA, WRITE, DONE.
REQ-019 SHALL assert ctrl_st_rdy only in IDLE; the handshake completes on a rising edge where ctrl_st_vld and ctrl_st_rdy are both 1.
REQ-020 SHALL, on a handshake, latch start_addr, row_len and row_dir, clear the row counter, and go IDLE->WAIT_DATA.
REQ-021 SHALL assert buf_mxu_rdy only in WAIT_DATA.
REQ-022 SHALL, on an edge in WAIT_DATA with mxu_data_vld=1, capture all ROWS rows into an internal tile buffer and go WAIT_DATA->WRITE.
REQ-023 SHALL ignore mxu_data_vld in every state other than WAIT_DATA; the tile buffer is not modified.
REQ-024 SHALL, in WRITE, drive exactly one row per cycle: ram_cen=ram_wen=1, ram_din=buffer row cnt, ram_addr=start_addr+cnt if row_dir=1, else start_addr-cnt.
REQ-025 SHALL compute ram_addr modulo 2^ADDR_W, so it wraps 255->0 and 0->255 with no error indication.
REQ-026 SHALL increment cnt each WRITE cycle; when cnt==row_len it goes WRITE->DONE, giving exactly row_len+1 write cycles.
REQ-027 SHALL drive st_done=1 for exactly the single DONE cycle, then go DONE->IDLE.
REQ-028 SHALL keep ram_cen, ram_wen and st_done at 0 outside WRITE/DONE as applicable; ram_addr and ram_din are 0 outside WRITE.
REQ-029 SHALL place the first write in the cycle after the tile-capture edge; command-to-done latency = 1 (WAIT_DATA entry) + data wait + (row_len+1) + 1.
REQ-030 SHALL ignore ctrl_st_vld outside IDLE; a command held across DONE is accepted on the first IDLE edge.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE, cnt=0, ctrl_st_rdy=1, buf_mxu_rdy=0, ram_cen=ram_wen=0, ram_addr=0, ram_din=0, st_done=0.
REQ-032 SHALL abandon any in-progress command on reset with no further writes; the tile buffer need not be cleared.

Verification
REQ-033 Bench SHALL cover: start=0x10, len=3, dir=1, tile row i = {16{i[7:0]}} -> 4 writes addr 0x10..0x13, din rows 0..3, st_done 1 cycle after addr 0x13.
REQ-034 Bench SHALL cover: start=0xFE, len=3, dir=1 -> addr 0xFE,0xFF,0x00,0x01; then start=0x01, len=2, dir=0 -> addr 0x01,0x00,0xFF.
REQ-035 Bench SHALL cover: mxu_data_vld pulsed in IDLE, then a command issued, then a tile with row0=0xAA.. -> writes use the second tile only.
REQ-036 Bench SHALL cover: len=15 -> 16 consecutive writes, din = rows 0..15 in order; ctrl_st_rdy=0 throughout and a concurrent ctrl_st_vld is not accepted until IDLE.
REQ-037 Bench SHALL cover: rst_n asserted on the 3rd write of len=7 -> ram_cen=0 immediately; after release, ctrl_st_rdy=1 and no further writes occur.
REQ-038 Bench SHALL cover: len=0 -> exactly 1 write, then st_done the next cycle.
